// File: rtl/rename_map_table.sv
// rename_map_table
//   R10K-style register rename map for a WIDTH-way dispatch group.
//   Maps each architectural register to a physical tag plus a ready bit.
//   Sources and the old destination mapping (told) are read combinationally,
//   with bypass from older ways of the same group. CDB broadcasts set ready
//   bits in the live table and in every checkpoint. A circular checkpoint
//   buffer allows a mispredicted branch to restore the map in one cycle.
//
// Ports
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   ren_valid/rs1/rs2/rd/new_preg  per-way rename request (rd == 0: no destination)
//   rs1_preg/rs1_rdy, rs2_preg/rs2_rdy, told_preg   per-way combinational results
//   cdb_valid/cdb_preg             completion broadcasts
//   ckpt_req/ckpt_way              snapshot after ways 0..ckpt_way of this group
//   ckpt_id/ckpt_full/ckpt_empty   checkpoint buffer status (ckpt_id = next id)
//   ckpt_release                   free the oldest checkpoint
//   recover_valid/recover_id       restore live checkpoint recover_id
module rename_map_table #(
    parameter  int ARCH_REGS  = 32,
    parameter  int PHYS_REGS  = 64,
    parameter  int WIDTH      = 2,
    parameter  int CDB_WIDTH  = 2,
    parameter  int CKPT_DEPTH = 4,
    localparam int AW  = $clog2(ARCH_REGS),
    localparam int PW  = $clog2(PHYS_REGS),
    localparam int CW  = $clog2(CKPT_DEPTH),
    localparam int WW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CDW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        ren_valid,
    input  logic [WIDTH*AW-1:0]     ren_rs1,
    input  logic [WIDTH*AW-1:0]     ren_rs2,
    input  logic [WIDTH*AW-1:0]     ren_rd,
    input  logic [WIDTH*PW-1:0]     ren_new_preg,
    output logic [WIDTH*PW-1:0]     rs1_preg,
    output logic [WIDTH*PW-1:0]     rs2_preg,
    output logic [WIDTH-1:0]        rs1_rdy,
    output logic [WIDTH-1:0]        rs2_rdy,
    output logic [WIDTH*PW-1:0]     told_preg,
    input  logic [CDB_WIDTH-1:0]    cdb_valid,
    input  logic [CDB_WIDTH*PW-1:0] cdb_preg,
    input  logic                    ckpt_req,
    input  logic [WW-1:0]           ckpt_way,
    output logic [CW-1:0]           ckpt_id,
    output logic                    ckpt_full,
    output logic                    ckpt_empty,
    input  logic                    ckpt_release,
    input  logic                    recover_valid,
    input  logic [CW-1:0]           recover_id
);

    logic [PW-1:0]        map_q       [ARCH_REGS];
    logic [ARCH_REGS-1:0] rdy_q;
    logic [PW-1:0]        ckpt_map_q  [CKPT_DEPTH][ARCH_REGS];
    logic [ARCH_REGS-1:0] ckpt_rdy_q  [CKPT_DEPTH];
    logic [ARCH_REGS-1:0] ckpt_rdy_nxt[CKPT_DEPTH];
    logic [CW-1:0]        head_q, tail_q;
    logic [CW:0]          count_q;

    logic [PW-1:0]        nxt_map [ARCH_REGS];
    logic [ARCH_REGS-1:0] nxt_rdy;
    logic [PW-1:0]        snap_map[ARCH_REGS];
    logic [ARCH_REGS-1:0] snap_rdy;

    logic push, pop, recover_live;

    assign ckpt_id    = tail_q;
    assign ckpt_full  = (count_q == (CW+1)'(CKPT_DEPTH));
    assign ckpt_empty = (count_q == '0);
    assign push       = ckpt_req && !ckpt_full && !recover_valid;
    assign pop        = ckpt_release && !ckpt_empty;

    function automatic logic cdb_hit(input logic [PW-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int unsigned c = 0; c < CDB_WIDTH; c++)
            if (cdb_valid[CDW'(c)] && cdb_preg[c*PW +: PW] == tag)
                hit = 1'b1;
        return hit;
    endfunction

    // {tag, ready} seen by way `way` for arch reg `areg`; the youngest older
    // way renaming the same register overrides the table.
    function automatic logic [PW:0] lookup(input int unsigned way, input logic [AW-1:0] areg);
        logic [PW-1:0] tag;
        logic          rdy;
        tag = map_q[areg];
        rdy = rdy_q[areg] | cdb_hit(map_q[areg]);
        for (int unsigned i = 0; i < WIDTH; i++)
            if (i < way && ren_valid[WW'(i)] && ren_rd[i*AW +: AW] != '0
                && ren_rd[i*AW +: AW] == areg) begin
                tag = ren_new_preg[i*PW +: PW];
                rdy = 1'b0;
            end
        if (areg == '0) begin
            tag = '0;
            rdy = 1'b1;
        end
        return {tag, rdy};
    endfunction

    always_comb begin
        rs1_preg  = '0;
        rs2_preg  = '0;
        rs1_rdy   = '0;
        rs2_rdy   = '0;
        told_preg = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            {rs1_preg[j*PW +: PW], rs1_rdy[WW'(j)]} = lookup(j, ren_rs1[j*AW +: AW]);
            {rs2_preg[j*PW +: PW], rs2_rdy[WW'(j)]} = lookup(j, ren_rs2[j*AW +: AW]);
            told_preg[j*PW +: PW] = lookup(j, ren_rd[j*AW +: AW]) >> 1;
        end
    end

    // CDB is applied to the current table before the group's renames, so a
    // freshly renamed entry always starts not-ready. The snapshot is taken
    // right after the branch way.
    always_comb begin
        for (int unsigned a = 0; a < ARCH_REGS; a++) begin
            nxt_map[AW'(a)] = map_q[AW'(a)];
            nxt_rdy[AW'(a)] = rdy_q[AW'(a)] | cdb_hit(map_q[AW'(a)]);
        end
        snap_map = nxt_map;
        snap_rdy = nxt_rdy;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ren_valid[WW'(i)] && ren_rd[i*AW +: AW] != '0) begin
                nxt_map[ren_rd[i*AW +: AW]] = ren_new_preg[i*PW +: PW];
                nxt_rdy[ren_rd[i*AW +: AW]] = 1'b0;
            end
            if (WW'(i) == ckpt_way) begin
                snap_map = nxt_map;
                snap_rdy = nxt_rdy;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < CKPT_DEPTH; k++)
            for (int unsigned a = 0; a < ARCH_REGS; a++)
                ckpt_rdy_nxt[CW'(k)][AW'(a)] = ckpt_rdy_q[CW'(k)][AW'(a)]
                                              | cdb_hit(ckpt_map_q[CW'(k)][AW'(a)]);
    end

    // Live table and buffer pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned a = 0; a < ARCH_REGS; a++)
                map_q[AW'(a)] <= PW'(a);
            rdy_q   <= '1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (recover_valid) begin
            map_q   <= ckpt_map_q[recover_id];
            rdy_q   <= ckpt_rdy_nxt[recover_id];
            tail_q  <= recover_id + 1'b1;
            // Restored checkpoint stays live, so count is never zero before
            // the same-cycle release is taken off.
            head_q  <= head_q + CW'(ckpt_release);
            count_q <= {1'b0, CW'(recover_id - head_q)} + (CW+1)'(1)
                       - (CW+1)'(ckpt_release);
        end else begin
            map_q   <= nxt_map;
            rdy_q   <= nxt_rdy;
            tail_q  <= tail_q + CW'(push);
            head_q  <= head_q + CW'(pop);
            count_q <= count_q + (CW+1)'(push) - (CW+1)'(pop);
        end
    end

    // Checkpoint storage; contents are meaningless once dead, so no reset.
    always_ff @(posedge clock) begin
        for (int unsigned k = 0; k < CKPT_DEPTH; k++) begin
            if (push && tail_q == CW'(k)) begin
                ckpt_map_q[CW'(k)] <= snap_map;
                ckpt_rdy_q[CW'(k)] <= snap_rdy;
            end else begin
                ckpt_rdy_q[CW'(k)] <= ckpt_rdy_nxt[CW'(k)];
            end
        end
    end

    assign recover_live = ({1'b0, CW'(recover_id - head_q)} < count_q);

    recover_id_live: assert property (@(posedge clock) disable iff (reset)
        recover_valid |-> recover_live);

endmodule
